// File: rtl/hyperbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_pkg
//  Purpose  : Shared types and sizing helpers for the HyperBus read packer.
//  Revision : 1.0 - initial release
// ============================================================================
package hyperbus_pkg;

  localparam int unsigned WORD_W = 16;

  // Packer control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } rx_state_e;

  // Read burst descriptor, sized for the widest supported counter (LEN_W <= 32)
  typedef struct packed {
    logic [31:0] words;
    logic [7:0]  offset;
  } rx_cmd_t;

  // 16-bit words carried by one output beat
  function automatic int unsigned words_per_beat(input int unsigned dw);
    return dw / WORD_W;
  endfunction

  // Width of a lane index; beats always hold at least two words
  function automatic int unsigned lane_bits(input int unsigned dw);
    return $clog2(dw / WORD_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hyperbus_rx_beat_reg.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_rx_beat_reg
//  Purpose  : Single-entry valid/ready output register holding one packed
//             beat {data, strb, last, err}. A load on the same edge as an
//             output handshake replaces the entry and keeps valid asserted.
//  Revision : 1.0 - initial release
// ============================================================================
module hyperbus_rx_beat_reg #(
  parameter int DW = 64
) (
  input  logic            clk0,
  input  logic            rst_ni,
  input  logic            load,
  input  logic [DW-1:0]   load_data,
  input  logic [DW/8-1:0] load_strb,
  input  logic            load_last,
  input  logic            load_err,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [DW/8-1:0] out_strb,
  output logic            out_last,
  output logic            out_err
);

  // Capture a completed beat, or retire the current one on handshake
  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_strb  <= load_strb;
      out_last  <= load_last;
      out_err   <= load_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hyperbus_rx_packer.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_rx_packer
//  Purpose  : Packs 16-bit words from the HyperBus read CDC FIFO into AXI_DW
//             wide read beats with byte strobes, last flag and error flag.
//             Optional idle timeout enabled by HYPERBUS_RX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module hyperbus_rx_packer
  import hyperbus_pkg::*;
#(
  parameter int AXI_DW = 64,
  parameter int LEN_W  = 16,
  parameter int TO_W   = 16
) (
  input  logic                          clk0,
  input  logic                          rst_ni,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [LEN_W-1:0]              cmd_words_i,
  input  logic [lane_bits(AXI_DW)-1:0]  cmd_offset_i,
  input  logic [TO_W-1:0]               cfg_timeout_i,
  input  logic                          rx_valid_i,
  input  logic [15:0]                   rx_data_i,
  output logic                          rx_ready_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [AXI_DW-1:0]             rdata_o,
  output logic [AXI_DW/8-1:0]           rstrb_o,
  output logic                          rlast_o,
  output logic                          rerr_o
);

  localparam int NW = words_per_beat(AXI_DW);
  localparam int LW = lane_bits(AXI_DW);
  localparam int SW = AXI_DW / 8;

  rx_state_e         state;
  logic [LEN_W:0]    remaining;
  logic [LW-1:0]     lane;
  logic [AXI_DW-1:0] acc;
  logic [SW-1:0]     acc_strb;
  logic [AXI_DW-1:0] beat_data;
  logic [SW-1:0]     beat_strb;
  logic [AXI_DW-1:0] load_data;
  logic [SW-1:0]     load_strb;
  logic              pop;
  logic              last_word;
  logic              beat_done;
  logic              stalled;
  logic              timeout_hit;
  logic              load_beat;
  rx_cmd_t           cmd_in;
  logic              unused_cmd;

  assign cmd_in     = '{words: 32'(cmd_words_i), offset: 8'(cmd_offset_i)};
  assign unused_cmd = ^cmd_in;

  // Word path: the incoming word replaces its lane in the accumulator
  for (genvar n = 0; n < NW; n++) begin : g_lane
    assign beat_data[16*n +: 16] = (lane == LW'(n)) ? rx_data_i : acc[16*n +: 16];
    assign beat_strb[2*n +: 2]   = (lane == LW'(n)) ? 2'b11 : acc_strb[2*n +: 2];
  end

  assign pop       = rx_valid_i && rx_ready_o;
  assign last_word = (remaining == (LEN_W+1)'(1));
  assign beat_done = (lane == LW'(NW - 1)) || last_word;
  assign stalled   = rvalid_o && !rready_i;

  // FIFO pop: discard outside COLLECT, respect beat backpressure inside it
  always_comb begin
    rx_ready_o = 1'b1;
    if (state == COLLECT) begin
      rx_ready_o = !rvalid_o || rready_i;
    end
  end

`ifdef HYPERBUS_RX_TIMEOUT_EN
  logic [TO_W-1:0] idle_cnt;

  // Idle counter: counts pop-free cycles in COLLECT, frozen under backpressure
  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt <= '0;
    end else if (state != COLLECT || pop) begin
      idle_cnt <= '0;
    end else if (!stalled && idle_cnt != '1) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == COLLECT) && !pop && !stalled &&
                       (cfg_timeout_i != '0) && (idle_cnt >= cfg_timeout_i);
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout_i;
  assign timeout_hit    = 1'b0;
`endif

  // A timeout flushes whatever has been accumulated, possibly nothing
  assign load_beat = (state == COLLECT) && ((pop && beat_done) || timeout_hit);
  assign load_data = timeout_hit ? acc : beat_data;
  assign load_strb = timeout_hit ? acc_strb : beat_strb;

  // Control FSM with word counter, lane pointer and accumulator
  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      remaining   <= '0;
      lane        <= '0;
      acc         <= '0;
      acc_strb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            remaining   <= (LEN_W+1)'(cmd_in.words[LEN_W-1:0]) + (LEN_W+1)'(1);
            lane        <= cmd_in.offset[LW-1:0];
            acc         <= '0;
            acc_strb    <= '0;
            cmd_ready_o <= 1'b0;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (pop) begin
            remaining <= remaining - (LEN_W+1)'(1);
            if (beat_done) begin
              acc      <= '0;
              acc_strb <= '0;
              lane     <= '0;
              if (last_word) begin
                state <= DRAIN;
              end
            end else begin
              acc      <= beat_data;
              acc_strb <= beat_strb;
              lane     <= lane + LW'(1);
            end
          end else if (timeout_hit) begin
            acc       <= '0;
            acc_strb  <= '0;
            lane      <= '0;
            remaining <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (rvalid_o && rready_i) begin
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  hyperbus_rx_beat_reg #(
    .DW (AXI_DW)
  ) u_beat_reg (
    .clk0      (clk0),
    .rst_ni    (rst_ni),
    .load      (load_beat),
    .load_data (load_data),
    .load_strb (load_strb),
    .load_last (timeout_hit || last_word),
    .load_err  (timeout_hit),
    .out_ready (rready_i),
    .out_valid (rvalid_o),
    .out_data  (rdata_o),
    .out_strb  (rstrb_o),
    .out_last  (rlast_o),
    .out_err   (rerr_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_rx_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hyperbus_rx_packer
//  Purpose  : Scoreboard bench for hyperbus_rx_packer (AXI_DW=64).
//             Timeout case is built only with HYPERBUS_RX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hyperbus_rx_packer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk0 = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic [15:0] cmd_words = '0;
  logic [1:0]  cmd_offset = '0;
  logic [15:0] cfg_timeout = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_ready_o;
  logic        rvalid_o;
  logic        rready = 1'b1;
  logic [63:0] rdata_o;
  logic [7:0]  rstrb_o;
  logic        rlast_o;
  logic        rerr_o;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  hyperbus_rx_packer #(
    .AXI_DW (64),
    .LEN_W  (16),
    .TO_W   (16)
  ) dut (
    .clk0          (clk0),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_words_i   (cmd_words),
    .cmd_offset_i  (cmd_offset),
    .cfg_timeout_i (cfg_timeout),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .rx_ready_o    (rx_ready_o),
    .rvalid_o      (rvalid_o),
    .rready_i      (rready),
    .rdata_o       (rdata_o),
    .rstrb_o       (rstrb_o),
    .rlast_o       (rlast_o),
    .rerr_o        (rerr_o)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is compared with the head of the scoreboard
  initial begin
    beat_t e;
    forever begin
      @(negedge clk0);
      if (rst_ni && rvalid_o && rready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data=%h strb=%h last=%b err=%b with empty scoreboard",
                   rdata_o, rstrb_o, rlast_o, rerr_o);
        end else begin
          e = exp_q.pop_front();
          if ({rdata_o, rstrb_o, rlast_o, rerr_o} !== e) begin
            errors++;
            $display("FAIL beat: got data=%h strb=%h last=%b err=%b expected data=%h strb=%h last=%b err=%b",
                     rdata_o, rstrb_o, rlast_o, rerr_o, e.data, e.strb, e.last, e.err);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [15:0] d);
    logic popped;
    int   g = 0;
    rx_valid = 1'b1;
    rx_data  = d;
    forever begin
      @(negedge clk0);
      popped = rx_ready_o;
      @(posedge clk0);
      #1;
      if (popped) break;
      g++;
      if (g > 1000) begin
        chk("rx_pop_timeout", 64'(g), 64'd0);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [15:0] w, input logic [1:0] off);
    logic acc;
    int   g = 0;
    cmd_words  = w;
    cmd_offset = off;
    cmd_valid  = 1'b1;
    forever begin
      @(negedge clk0);
      acc = cmd_ready_o;
      @(posedge clk0);
      #1;
      if (acc) break;
      g++;
      if (g > 1000) begin
        chk("cmd_accept_timeout", 64'(g), 64'd0);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // Position model: word i lands at absolute lane offset+i
  task automatic expect_burst(input int n, input int off, input logic [15:0] base);
    beat_t b;
    int    p;
    int    cur = 0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      p = off + i;
      if (p / 4 != cur) begin
        exp_q.push_back(b);
        b   = '0;
        cur = p / 4;
      end
      b.data[16*(p%4) +: 16] = base + 16'(i);
      b.strb[2*(p%4) +: 2]   = 2'b11;
    end
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic run_burst(input int n, input int off, input logic [15:0] base);
    expect_burst(n, off, base);
    send_cmd(16'(n - 1), 2'(off));
    for (int i = 0; i < n; i++) send_word(base + 16'(i));
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(posedge clk0);
      g++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk0);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk0);
    #1;
    chk("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("reset_rvalid", 64'(rvalid_o), 64'd0);
    chk("reset_rdata", rdata_o, 64'd0);
    chk("reset_rstrb", 64'(rstrb_o), 64'd0);
    chk("reset_rlast_rerr", 64'({rlast_o, rerr_o}), 64'd0);
    chk("reset_rx_ready", 64'(rx_ready_o), 64'd1);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk0);
    #1;

    // Stray words in IDLE are discarded
    send_word(16'hDEAD);
    send_word(16'hBEEF);
    chk("stray_no_beat", 64'(rvalid_o), 64'd0);

    // Four aligned words, one full beat, latency one cycle after last pop
    exp_q.push_back('{data: 64'h4444_3333_2222_1111, strb: 8'hFF, last: 1'b1, err: 1'b0});
    send_cmd(16'd3, 2'd0);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    chk("t1_rvalid_before_last", 64'(rvalid_o), 64'd0);
    send_word(16'h4444);
    chk("t1_rvalid_after_last", 64'(rvalid_o), 64'd1);
    wait_drain(50);

    // Offset 3, five words: lane3-only beat then a full final beat
    exp_q.push_back('{data: 64'hA000_0000_0000_0000, strb: 8'hC0, last: 1'b0, err: 1'b0});
    exp_q.push_back('{data: 64'hA004_A003_A002_A001, strb: 8'hFF, last: 1'b1, err: 1'b0});
    send_cmd(16'd4, 2'd3);
    for (int i = 0; i < 5; i++) send_word(16'hA000 + 16'(i));
    wait_drain(50);

    // Partial final beat, and offset with wrap into a second beat
    run_burst(6, 0, 16'h5000);
    wait_drain(50);
    run_burst(3, 2, 16'h6000);
    wait_drain(50);

    // Backpressure: hold rready low for 10 cycles after beat0
    expect_burst(16, 0, 16'h7000);
    send_cmd(16'd15, 2'd0);
    fork
      for (int i = 0; i < 16; i++) send_word(16'h7000 + 16'(i));
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk0);
          g++;
        end while (!rvalid_o && g < 100);
        chk("bp_beat0_seen", 64'(rvalid_o), 64'd1);
        @(posedge clk0);
        #1;
        rready = 1'b0;
        repeat (10) @(posedge clk0);
        @(negedge clk0);
        chk("bp_rx_ready_low", 64'(rx_ready_o), 64'd0);
        chk("bp_rvalid_held", 64'(rvalid_o), 64'd1);
        @(posedge clk0);
        #1;
        rready = 1'b1;
      end
    join
    wait_drain(100);

    // Maximum burst length: 65536 words, 16384 beats
    run_burst(65536, 0, 16'h0000);
    wait_drain(200);

`ifdef HYPERBUS_RX_TIMEOUT_EN
    // Timeout flushes the partial beat with rlast and rerr
    cfg_timeout = 16'd8;
    exp_q.push_back('{data: 64'h0000_0000_B002_B001, strb: 8'h0F, last: 1'b1, err: 1'b1});
    send_cmd(16'd3, 2'd0);
    send_word(16'hB001);
    send_word(16'hB002);
    wait_drain(100);
    cfg_timeout = 16'd0;
`endif

    // Reset mid-burst with a beat pending
    rready = 1'b0;
    send_cmd(16'd7, 2'd0);
    for (int i = 0; i < 4; i++) send_word(16'hE000 + 16'(i));
    chk("mid_rvalid_pending", 64'(rvalid_o), 64'd1);
    @(negedge clk0);
    rst_ni = 1'b0;
    #1;
    chk("mid_reset_rvalid", 64'(rvalid_o), 64'd0);
    chk("mid_reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    @(posedge clk0);
    #1;
    rst_ni = 1'b1;
    rready = 1'b1;
    @(posedge clk0);
    #1;
    run_burst(6, 1, 16'hC000);
    wait_drain(50);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
